// File: rtl/rv_instr_encoder.sv
// Encodes abstract ALU/load/branch requests into RV32I words and streams them into IMEM.
// Latency 1 (accept -> imem_we); req_ready only while a burst has slots left; start ignored while busy.
module rv_instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              illegal;
  logic              xfer;

  always_comb begin
    enc     = 32'h0000_0013;
    illegal = 1'b0;
    case (req_op)
      4'd0:  enc = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
      4'd1:  enc = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
      4'd2:  enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b0010011};
      4'd3:  enc = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
      4'd4:  enc = {req_imm[11:0], req_rs1, 3'b100, req_rd, 7'b0000011};
      4'd5:  enc = {req_imm[11:0], req_rs1, 3'b100, req_rd, 7'b0010011};
      4'd6:  enc = {req_imm[11:0], req_rs1, 3'b111, req_rd, 7'b0010011};
      4'd7:  enc = {7'b0000000, req_imm[4:0], req_rs1, 3'b101, req_rd, 7'b0010011};
      4'd8:  enc = {7'b0100000, req_imm[4:0], req_rs1, 3'b101, req_rd, 7'b0010011};
      4'd9:  enc = {7'b0000000, req_imm[4:0], req_rs1, 3'b001, req_rd, 7'b0010011};
      4'd10: enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                    req_imm[4:1], req_imm[11], 7'b1100011};
      // Illegal ops still consume their slot, filled with a NOP.
      default: illegal = 1'b1;
    endcase
  end

  assign req_ready = (state_q == LOAD) && (rem_q != '0);
  assign xfer      = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    imem_addr_d = imem_addr_q;
    rem_d       = rem_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          addr_d = base_addr;
          rem_d  = count;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d        = 1'b1;
          imem_addr_d = addr_q;
          wdata_d     = enc;
          addr_d      = addr_q + ADDR_W'(4);
          rem_d       = rem_q - CNT_W'(1);
          if (illegal) err_d = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      imem_addr_q <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      imem_addr_q <= imem_addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      we_q        <= we_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
